// File: rtl/mr_ntt_pkg.sv
// Shared constants, types and leg-index helper for the 128-point NTT bank address generator.
package mr_ntt_pkg;

    localparam int N      = 128;
    localparam int NBANK  = 4;
    localparam int AW     = 5;
    localparam int NSTAGE = 4;
    localparam int IW     = $clog2(N);

    typedef logic [$clog2(NSTAGE)-1:0] stage_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Leg k of a radix-4 stage adds k*4^s to the base, which drops k into the two zeroed bits.
    function automatic logic [IW-1:0] leg_index(input stage_t stage, input logic [AW-1:0] c,
                                                input logic [1:0] k);
        logic [IW-1:0] idx;
        case (stage)
            2'd0:    idx = {c, k};
            2'd1:    idx = {c[4:2], k, c[1:0]};
            2'd2:    idx = {c[4], k, c[3:0]};
            default: idx = {k[1], c[4:1], k[0], c[0]};
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/bank_map.sv
// Maps a 7-bit point index to its bank number and word address inside that bank.
module bank_map
    import mr_ntt_pkg::*;
(
    input  logic [IW-1:0] idx,
    output logic [1:0]    bank,
    output logic [AW-1:0] addr
);

    assign addr = idx[IW-1:2];
    // Digit-sum skew keeps all four legs of every beat in distinct banks.
    assign bank = idx[1:0] + idx[3:2] + idx[5:4] + {1'b0, idx[6]};

endmodule

// File: rtl/bank_addr_gen.sv
// Conflict-free bank address sequencer for one 128-point transform pass (4 stages x 32 beats).
// Optional macro BANK_AG_INTT_EN adds an inv input that runs the stages in reverse order.
module bank_addr_gen
    import mr_ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
`ifdef BANK_AG_INTT_EN
    input  logic          inv,
`endif
    output logic          busy,
    output logic          valid_o,
    output logic          done,
    output logic [1:0]    stage_o,
    output logic [AW-1:0] b0,
    output logic [AW-1:0] b1,
    output logic [AW-1:0] b2,
    output logic [AW-1:0] b3,
    output logic [1:0]    bank_0,
    output logic [1:0]    bank_1,
    output logic [1:0]    bank_2,
    output logic [1:0]    bank_3,
    output logic [1:0]    sel_a_0,
    output logic [1:0]    sel_a_1,
    output logic [1:0]    sel_a_2,
    output logic [1:0]    sel_a_3
);

    state_t        state_q, state_d;
    stage_t        stage_q, stage_d;
    logic [AW-1:0] c_q, c_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    stage_t        first_stage, last_stage, next_stage;
    logic          last_beat;

    logic [IW-1:0] leg_idx  [NBANK];
    logic [AW-1:0] leg_addr [NBANK];
    logic [1:0]    leg_bank [NBANK];
    logic [AW-1:0] addr_q [NBANK], addr_d [NBANK];
    logic [1:0]    bank_q [NBANK], bank_d [NBANK];
    logic [1:0]    sel_q  [NBANK], sel_d  [NBANK];

`ifdef BANK_AG_INTT_EN
    logic inv_q, inv_d;

    assign inv_d       = (state_q == IDLE && start) ? inv : inv_q;
    assign first_stage = inv ? 2'd3 : 2'd0;
    assign last_stage  = inv_q ? 2'd0 : 2'd3;
    assign next_stage  = inv_q ? stage_q - 2'd1 : stage_q + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) inv_q <= 1'b0;
        else     inv_q <= inv_d;
    end
`else
    assign first_stage = 2'd0;
    assign last_stage  = 2'd3;
    assign next_stage  = stage_q + 2'd1;
`endif

    assign last_beat = (stage_q == last_stage) && (c_q == '1);

    // A beat counts as taken only on an unstalled edge; a stalled beat is shown again with valid.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        c_d     = c_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = first_stage;
                    c_d     = '0;
                    valid_d = ~stall;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (!valid_q) begin
                        valid_d = 1'b1;
                        done_d  = last_beat;
                    end else if (last_beat) begin
                        state_d = IDLE;
                        stage_d = '0;
                        c_d     = '0;
                    end else begin
                        valid_d = 1'b1;
                        c_d     = c_q + AW'(1);
                        if (c_q == '1) stage_d = next_stage;
                        done_d  = (stage_q == last_stage) && (c_q == AW'(30));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NBANK; k++) begin : g_leg
        assign leg_idx[k] = leg_index(stage_d, c_d, 2'(k));
        bank_map u_bank_map (
            .idx  (leg_idx[k]),
            .bank (leg_bank[k]),
            .addr (leg_addr[k])
        );
    end

    // Address outputs are precomputed from the next beat so they leave the block registered.
    always_comb begin
        for (int k = 0; k < NBANK; k++) begin
            addr_d[k] = '0;
            bank_d[k] = '0;
            sel_d[k]  = '0;
        end
        if (state_d == RUN) begin
            for (int k = 0; k < NBANK; k++) begin
                addr_d[k]           = leg_addr[k];
                bank_d[k]           = leg_bank[k];
                sel_d[leg_bank[k]]  = 2'(k);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < NBANK; k++) begin
                addr_q[k] <= '0;
                bank_q[k] <= '0;
                sel_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            for (int k = 0; k < NBANK; k++) begin
                addr_q[k] <= addr_d[k];
                bank_q[k] <= bank_d[k];
                sel_q[k]  <= sel_d[k];
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign valid_o = valid_q;
    assign done    = done_q;
    assign stage_o = stage_q;
    assign b0      = addr_q[0];
    assign b1      = addr_q[1];
    assign b2      = addr_q[2];
    assign b3      = addr_q[3];
    assign bank_0  = bank_q[0];
    assign bank_1  = bank_q[1];
    assign bank_2  = bank_q[2];
    assign bank_3  = bank_q[3];
    assign sel_a_0 = sel_q[0];
    assign sel_a_1 = sel_q[1];
    assign sel_a_2 = sel_q[2];
    assign sel_a_3 = sel_q[3];

endmodule

// File: tb/tb_bank_addr_gen.sv
// Directed self-checking bench for bank_addr_gen (default build, forward stage order).
module tb_bank_addr_gen;

    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic       busy, valid_o, done;
    logic [1:0] stage_o;
    logic [4:0] b0, b1, b2, b3;
    logic [1:0] bank_0, bank_1, bank_2, bank_3;
    logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;

    logic [4:0] b_o   [4];
    logic [1:0] bk_o  [4];
    logic [1:0] sel_o [4];

    int n_checks = 0;
    int n_fail   = 0;
    int hits [4][32];

    bank_addr_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .busy    (busy),
        .valid_o (valid_o),
        .done    (done),
        .stage_o (stage_o),
        .b0      (b0),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3),
        .bank_0  (bank_0),
        .bank_1  (bank_1),
        .bank_2  (bank_2),
        .bank_3  (bank_3),
        .sel_a_0 (sel_a_0),
        .sel_a_1 (sel_a_1),
        .sel_a_2 (sel_a_2),
        .sel_a_3 (sel_a_3)
    );

    always #5 clk = ~clk;

    assign b_o[0]   = b0;      assign b_o[1]   = b1;      assign b_o[2]   = b2;      assign b_o[3]   = b3;
    assign bk_o[0]  = bank_0;  assign bk_o[1]  = bank_1;  assign bk_o[2]  = bank_2;  assign bk_o[3]  = bank_3;
    assign sel_o[0] = sel_a_0; assign sel_o[1] = sel_a_1; assign sel_o[2] = sel_a_2; assign sel_o[3] = sel_a_3;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Index of leg k in beat (s, c), written as base + k*4^s arithmetic.
    function automatic int model_idx(input int s, input int c, input int k);
        int j;
        case (s)
            0:       return c * 4 + k;
            1:       return (c / 4) * 16 + (c % 4) + k * 4;
            2:       return (c / 16) * 64 + (c % 16) + k * 16;
            default: begin
                j = (c / 2) * 4 + (c % 2);
                return j + (k % 2) * 2 + (k / 2) * 64;
            end
        endcase
    endfunction

    function automatic int model_bank(input int i);
        return (i % 4 + (i / 4) % 4 + (i / 16) % 4 + i / 64) % 4;
    endfunction

    task automatic check_outputs(input int n, input logic exp_valid, input logic exp_done);
        int s, c, idx, bk;
        int sel [4];
        s = n / 32;
        c = n % 32;
        check($sformatf("busy@%0d", n), busy, 1);
        check($sformatf("valid@%0d", n), valid_o, exp_valid);
        check($sformatf("done@%0d", n), done, exp_done);
        check($sformatf("stage@%0d", n), stage_o, s);
        for (int k = 0; k < 4; k++) begin
            idx = model_idx(s, c, k);
            bk  = model_bank(idx);
            sel[bk] = k;
            check($sformatf("b%0d@%0d", k, n), b_o[k], idx / 4);
            check($sformatf("bank%0d@%0d", k, n), bk_o[k], bk);
        end
        for (int x = 0; x < 4; x++)
            check($sformatf("sel_a_%0d@%0d", x, n), sel_o[x], sel[x]);
    endtask

    task automatic check_beat(input int n);
        check_outputs(n, 1'b1, n == 127);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " valid"}, valid_o, 0);
        check({tag, " done"}, done, 0);
        check({tag, " stage"}, stage_o, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s b%0d", tag, k), b_o[k], 0);
            check($sformatf("%s bank%0d", tag, k), bk_o[k], 0);
            check($sformatf("%s sel%0d", tag, k), sel_o[x_of(k)], 0);
        end
    endtask

    function automatic int x_of(input int k);
        return k;
    endfunction

    task automatic check_vec(input string tag, input int e0, input int e1, input int e2, input int e3,
                             input int f0, input int f1, input int f2, input int f3,
                             input int g0, input int g1, input int g2, input int g3);
        check({tag, " b0"}, b0, e0); check({tag, " b1"}, b1, e1);
        check({tag, " b2"}, b2, e2); check({tag, " b3"}, b3, e3);
        check({tag, " bank_0"}, bank_0, f0); check({tag, " bank_1"}, bank_1, f1);
        check({tag, " bank_2"}, bank_2, f2); check({tag, " bank_3"}, bank_3, f3);
        check({tag, " sel_a_0"}, sel_a_0, g0); check({tag, " sel_a_1"}, sel_a_1, g1);
        check({tag, " sel_a_2"}, sel_a_2, g2); check({tag, " sel_a_3"}, sel_a_3, g3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int bad_cells;
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("idle");

        // Full pass with hand vectors, an ignored mid-pass start and bank/address coverage.
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 32; a++)
                hits[b][a] = 0;
        pulse_start();
        for (int n = 0; n < 128; n++) begin
            if (n > 0) step();
            check_beat(n);
            if (n == 0)  check_vec("s0c0",  0, 0, 0, 0,   0, 1, 2, 3,  0, 1, 2, 3);
            if (n == 33) check_vec("s1c1",  0, 1, 2, 3,   1, 2, 3, 0,  3, 0, 1, 2);
            if (n == 99) check_vec("s3c3",  1, 1, 17, 17, 2, 0, 3, 1,  1, 3, 0, 2);
            for (int k = 0; k < 4; k++)
                hits[bk_o[k]][b_o[k]]++;
            start = (n == 10);
        end
        step();
        check("busy after done", busy, 0);
        check("valid after done", valid_o, 0);
        bad_cells = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 32; a++)
                if (hits[b][a] != 4) bad_cells++;
        check("cells not hit 4 times", bad_cells, 0);

        // Stall five cycles while beat 40 is shown; it must come back once with valid.
        pulse_start();
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) step();
            check_beat(n);
        end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_outputs(40, 1'b0, 1'b0);
        end
        stall = 1'b0;
        for (int n = 40; n < 128; n++) begin
            step();
            check_beat(n);
        end
        step();
        check("busy after stalled pass", busy, 0);

        // Stall on the final beat: done drops, then returns with the re-issued beat.
        pulse_start();
        for (int n = 1; n < 128; n++) step();
        check_beat(127);
        stall = 1'b1;
        step();
        check_outputs(127, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        check_beat(127);
        step();
        check("busy after late stall", busy, 0);

        // Reset at beat 70, then restart from the beginning.
        pulse_start();
        for (int n = 1; n <= 70; n++) step();
        check_beat(70);
        rst = 1'b1;
        step();
        check_idle("midpass reset");
        rst = 1'b0;
        pulse_start();
        check_beat(0);
        step();
        check_beat(1);

        // Start together with stall from IDLE: first beat held, then issued.
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b1;
        stall = 1'b1;
        step();
        start = 1'b0;
        check_outputs(0, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        check_beat(0);
        step();
        check_beat(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
